// File: rtl/rram_cim_pkg.sv
// Shared definitions for the ternary RRAM compute-in-memory sequencer.
// Trit encoding, FSM state type and the trit sanitizer used on every inbound trit.
package rram_cim_pkg;

    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_BAD  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMacIssue,
        StMacWait,
        StDrain
    } cim_state_e;

    typedef struct packed {
        logic [1:0] trit;
        logic       bad;
    } trit_san_t;

    // The unused code 11 is replaced by zero and flagged so the caller can raise a fault.
    function automatic trit_san_t sanitize_trit(input logic [1:0] t);
        trit_san_t s;
        s.trit = TRIT_ZERO;
        s.bad  = 1'b0;
        case (t)
            TRIT_NEG, TRIT_ZERO, TRIT_POS: s.trit = t;
            TRIT_BAD:                      s.bad  = 1'b1;
            default:                       s.bad  = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rram_cim_result_buf.sv
// Column result buffer for the CIM sequencer: captures COLS signed 8-bit sums in one
// cycle and drains them one column per accepted beat, flagging the final column.
// Build macro RRAM_CIM_REQUANT_EN: each sum is reduced to a trit code before buffering.
module rram_cim_result_buf
    import rram_cim_pkg::*;
#(
    parameter int unsigned  COLS   = 16,
    parameter int           THRESH = 4,
    localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              zero_fill,
    input  logic [COLS*8-1:0] mac_result,
    input  logic              drain_en,
    input  logic              advance,
    output logic [7:0]        r_data,
    output logic [ColW-1:0]   r_col,
    output logic              r_last
);

    logic [7:0]      buf_q [COLS];
    logic [ColW-1:0] ptr_q;

    // Requant codes assume a positive threshold inside the signed 8-bit sum range.
    if (THRESH < 1 || THRESH > 127) begin : g_bad_thresh
        $error("rram_cim_result_buf: THRESH must be in 1..127");
    end

`ifdef RRAM_CIM_REQUANT_EN
    function automatic logic [7:0] quantize(input logic [7:0] sum);
        logic [7:0] q;
        q = 8'h00;
        if ($signed(sum) >= THRESH) begin
            q = {6'b0, TRIT_POS};
        end else if ($signed(sum) <= -THRESH) begin
            q = {6'b0, TRIT_NEG};
        end
        return q;
    endfunction
`else
    function automatic logic [7:0] quantize(input logic [7:0] sum);
        return sum;
    endfunction
`endif

    // Capture (or zero) all columns at once; a timed-out MAC must drain zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) buf_q[c] <= 8'h00;
        end else if (zero_fill) begin
            for (int c = 0; c < COLS; c++) buf_q[c] <= 8'h00;
        end else if (capture) begin
            for (int c = 0; c < COLS; c++) buf_q[c] <= quantize(mac_result[8*c +: 8]);
        end
    end

    // Drain pointer restarts at column 0 on every new result set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (capture || zero_fill) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (ptr_q == ColW'(COLS - 1)) ? '0 : ptr_q + ColW'(1);
        end
    end

    assign r_data = buf_q[ptr_q];
    assign r_col  = ptr_q;
    assign r_last = drain_en && (ptr_q == ColW'(COLS - 1));

endmodule

// File: rtl/rram_cim_sequencer.sv
// Initiator-side sequencer for the ternary RRAM crossbar: streams weights into the
// write port, issues MACs on activation vectors and drains the column sums serially.
// Build macro RRAM_CIM_REQUANT_EN: sums are requantized to trits (see result buffer).
module rram_cim_sequencer
    import rram_cim_pkg::*;
#(
    parameter int unsigned  ROWS    = 16,
    parameter int unsigned  COLS    = 16,
    parameter int unsigned  TIMEOUT = 15,
    parameter int           THRESH  = 4,
    localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned ColW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [1:0]        w_data,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [ROWS*2-1:0] x_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [7:0]        r_data,
    output logic [ColW-1:0]   r_col,
    output logic              r_last,
    output logic              busy,
    output logic              fault,
    input  logic              fault_clr,
    output logic [RowW-1:0]   xb_wr_row,
    output logic [ColW-1:0]   xb_wr_col,
    output logic [1:0]        xb_wr_data,
    output logic              xb_wr_en,
    output logic [ROWS*2-1:0] xb_input_vector,
    output logic              xb_mac_start,
    input  logic [COLS*8-1:0] xb_mac_result,
    input  logic              xb_mac_done
);

    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    cim_state_e        state_q, state_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [ROWS*2-1:0] vec_q, vec_d, x_clean;
    logic              x_bad;
    trit_san_t         w_san;
    logic              wr_en_q, wr_en_d;
    logic [RowW-1:0]   wr_row_q, wr_row_d;
    logic [ColW-1:0]   wr_col_q, wr_col_d;
    logic [1:0]        wr_data_q, wr_data_d;
    logic              fault_q, fault_d, fault_set;
    logic              x_rdy_q;
    logic              capture, zero_fill, r_fire;

    assign w_san = sanitize_trit(w_data);

    // Sanitize the whole activation vector and note whether any trit was invalid.
    always_comb begin
        x_clean = '0;
        x_bad   = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            trit_san_t s;
            s = sanitize_trit(x_data[2*r +: 2]);
            x_clean[2*r +: 2] = s.trit;
            x_bad = x_bad | s.bad;
        end
    end

    // Next-state and datapath control for the load / MAC / drain sequence.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        timer_d   = timer_q;
        vec_d     = vec_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        fault_set = 1'b0;
        capture   = 1'b0;
        zero_fill = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoad;
                    row_d   = '0;
                    col_d   = '0;
                end else if (x_valid && x_rdy_q) begin
                    state_d   = StMacIssue;
                    vec_d     = x_clean;
                    fault_set = x_bad;
                    timer_d   = '0;
                end
            end
            StLoad: begin
                if (w_valid) begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = row_q;
                    wr_col_d  = col_q;
                    wr_data_d = w_san.trit;
                    fault_set = w_san.bad;
                    if (col_q == ColW'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == RowW'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = StIdle;
                        end else begin
                            row_d = row_q + RowW'(1);
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end
            end
            StMacIssue: begin
                // Timer counts cycles since the start pulse.
                timer_d = timer_q + TmrW'(1);
                state_d = StMacWait;
            end
            StMacWait: begin
                timer_d = timer_q + TmrW'(1);
                if (xb_mac_done) begin
                    capture = 1'b1;
                    state_d = StDrain;
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    fault_set = 1'b1;
                    zero_fill = 1'b1;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (r_fire && r_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A fault raised in the same cycle as a clear must win.
        fault_d = (fault_q & ~(fault_clr & (state_q == StIdle))) | fault_set;
    end

    // State, counters, crossbar drive registers and sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            timer_q   <= '0;
            vec_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= 2'b00;
            fault_q   <= 1'b0;
            x_rdy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            timer_q   <= timer_d;
            vec_q     <= vec_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            fault_q   <= fault_d;
            x_rdy_q   <= (state_d == StIdle);
        end
    end

    assign w_ready         = (state_q == StLoad);
    // Registered so x_ready stays low during reset; load_start pre-empts an accept.
    assign x_ready         = x_rdy_q & ~load_start;
    assign busy            = (state_q != StIdle);
    assign r_valid         = (state_q == StDrain);
    assign r_fire          = r_valid & r_ready;
    assign fault           = fault_q;
    assign xb_mac_start    = (state_q == StMacIssue);
    assign xb_input_vector = vec_q;
    assign xb_wr_en        = wr_en_q;
    assign xb_wr_row       = wr_row_q;
    assign xb_wr_col       = wr_col_q;
    assign xb_wr_data      = wr_data_q;

    rram_cim_result_buf #(
        .COLS   (COLS),
        .THRESH (THRESH)
    ) u_result_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .zero_fill  (zero_fill),
        .mac_result (xb_mac_result),
        .drain_en   (r_valid),
        .advance    (r_fire),
        .r_data     (r_data),
        .r_col      (r_col),
        .r_last     (r_last)
    );

endmodule

// File: tb/tb_rram_cim_sequencer.sv
// Directed bench for rram_cim_sequencer with a behavioural crossbar model.
// Honours RRAM_CIM_REQUANT_EN when computing expected result beats.
module tb_rram_cim_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_start, w_valid, w_ready;
    logic [1:0]   w_data;
    logic         x_valid, x_ready;
    logic [31:0]  x_data;
    logic         r_valid, r_ready, r_last;
    logic [7:0]   r_data;
    logic [3:0]   r_col;
    logic         busy, fault, fault_clr;
    logic [3:0]   xb_wr_row, xb_wr_col;
    logic [1:0]   xb_wr_data;
    logic         xb_wr_en;
    logic [31:0]  xb_input_vector;
    logic         xb_mac_start, xb_mac_done;
    logic [127:0] xb_mac_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rram_cim_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_start      (load_start),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .x_data          (x_data),
        .r_valid         (r_valid),
        .r_ready         (r_ready),
        .r_data          (r_data),
        .r_col           (r_col),
        .r_last          (r_last),
        .busy            (busy),
        .fault           (fault),
        .fault_clr       (fault_clr),
        .xb_wr_row       (xb_wr_row),
        .xb_wr_col       (xb_wr_col),
        .xb_wr_data      (xb_wr_data),
        .xb_wr_en        (xb_wr_en),
        .xb_input_vector (xb_input_vector),
        .xb_mac_start    (xb_mac_start),
        .xb_mac_result   (xb_mac_result),
        .xb_mac_done     (xb_mac_done)
    );

    // ---------------- crossbar model ----------------
    logic [1:0]   wmem [16][16];
    int           wr_count = 0;
    logic [3:0]   log_row [256];
    logic [3:0]   log_col [256];
    logic [1:0]   log_data [256];
    logic         model_done = 1'b0;
    logic         stray_done = 1'b0;
    logic [127:0] model_result = '0;
    bit           respond = 1'b1;
    bit           use_override = 1'b0;
    logic [127:0] override_val = '0;

    assign xb_mac_done   = model_done | stray_done;
    assign xb_mac_result = model_result;

    function automatic int tv(input logic [1:0] t);
        if (t == 2'b01) return 1;
        if (t == 2'b10) return -1;
        return 0;
    endfunction

    function automatic logic [127:0] crossbar_sum();
        logic [127:0] res;
        int s;
        res = '0;
        for (int c = 0; c < 16; c++) begin
            s = 0;
            for (int r = 0; r < 16; r++) s += tv(wmem[r][c]) * tv(xb_input_vector[2*r +: 2]);
            res[8*c +: 8] = 8'(s);
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (xb_wr_en) begin
            wmem[xb_wr_row][xb_wr_col] = xb_wr_data;
            log_row[wr_count % 256]  = xb_wr_row;
            log_col[wr_count % 256]  = xb_wr_col;
            log_data[wr_count % 256] = xb_wr_data;
            wr_count++;
        end
    end

    // Done pulses two cycles after the start cycle.
    always begin
        @(negedge clk);
        if (xb_mac_start && respond) begin
            model_result = use_override ? override_val : crossbar_sum();
            @(negedge clk);
            @(negedge clk);
            model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] exp_r [16];

    function automatic logic [7:0] expect_r(input int s);
`ifdef RRAM_CIM_REQUANT_EN
        if (s >= 4) return 8'h01;
        if (s <= -4) return 8'h02;
        return 8'h00;
`else
        return 8'(s);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_weights(input bit bad_first);
        int base;
        base = wr_count;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_busy", busy, 1);
        check("load_w_ready", w_ready, 1);
        w_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w_data = (bad_first && i == 0) ? 2'b11 : 2'b01;
            tick();
        end
        w_valid = 1'b0;
        w_data  = 2'b00;
        check("load_busy_drop", busy, 0);
        check("load_w_ready_drop", w_ready, 0);
        tick();
        check("load_strobe_count", wr_count - base, 256);
        check("load_wr_en_end", xb_wr_en, 0);
        check("load_beat17_row", log_row[17], 1);
        check("load_beat17_col", log_col[17], 1);
        check("load_beat255_row", log_row[255], 15);
        check("load_beat255_col", log_col[255], 15);
        check("load_beat0_data", log_data[0], bad_first ? 2'b00 : 2'b01);
        check("load_fault", fault, bad_first);
    endtask

    // Accept a vector and check the one-cycle start pulse; returns in the cycle after start.
    task automatic mac_issue(input logic [31:0] xv, input logic [31:0] exp_vec);
        x_data  = xv;
        x_valid = 1'b1;
        check("x_ready_idle", x_ready, 1);
        tick();
        x_valid = 1'b0;
        check("mac_start", xb_mac_start, 1);
        check("mac_vec", xb_input_vector, exp_vec);
        check("mac_x_ready", x_ready, 0);
        check("mac_busy", busy, 1);
        tick();
        check("mac_start_pulse", xb_mac_start, 0);
    endtask

    task automatic drain(input bit bp);
        int  col;
        int  cyc;
        logic rdy;
        col = 0;
        cyc = 0;
        while (col < 16 && cyc < 100) begin
            if (r_valid) begin
                check("r_col", r_col, col);
                check("r_data", r_data, exp_r[col]);
                check("r_last", r_last, col == 15);
                rdy = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
                r_ready = rdy;
                tick();
                if (rdy) col++;
                else check("stall_valid", r_valid, 1);
            end else begin
                tick();
            end
            cyc++;
        end
        r_ready = 1'b0;
        check("drain_beats", col, 16);
        check("drain_valid_low", r_valid, 0);
        check("drain_idle", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n      = 1'b0;
        load_start = 1'b0;
        w_valid    = 1'b0;
        w_data     = 2'b00;
        x_valid    = 1'b0;
        x_data     = '0;
        r_ready    = 1'b0;
        fault_clr  = 1'b0;
        tick();
        tick();
        check("rst_x_ready", x_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_wr_en", xb_wr_en, 0);
        check("rst_mac_start", xb_mac_start, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_last", r_last, 0);
        check("rst_vec", xb_input_vector, 0);
        rst_n = 1'b1;
        tick();
        check("idle_x_ready", x_ready, 1);

        // Stray done in IDLE is ignored.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        check("stray_busy", busy, 0);
        tick();
        check("stray_r_valid", r_valid, 0);

        // Full load of +1 weights, then MAC with all +1 activations.
        load_weights(1'b0);
        for (int c = 0; c < 16; c++) exp_r[c] = expect_r(16);
        mac_issue(32'h5555_5555, 32'h5555_5555);
        tick();
        check("r_valid_early", r_valid, 0);
        tick();
        check("r_valid_latency", r_valid, 1);
        drain(1'b0);

        // Same MAC drained under backpressure.
        mac_issue(32'h5555_5555, 32'h5555_5555);
        tick();
        tick();
        check("bp_r_valid", r_valid, 1);
        drain(1'b1);

        // Invalid weight on beat 0; clear in IDLE.
        load_weights(1'b1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault_clr_idle", fault, 0);

        // Row 3 = 11 (forced to 0), row 5 = -1; w[0][0] is 0.
        exp_r[0] = expect_r(12);
        for (int c = 1; c < 16; c++) exp_r[c] = expect_r(13);
        mac_issue(32'h5555_59D5, 32'h5555_5915);
        check("x_bad_fault", fault, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault_clr_busy_ignored", fault, 1);
        check("vec_hold", xb_input_vector, 32'h5555_5915);
        tick();
        check("x_bad_r_valid", r_valid, 1);
        drain(1'b0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault_clr_after", fault, 0);

        // Timeout: crossbar stays silent.
        respond = 1'b0;
        for (int c = 0; c < 16; c++) exp_r[c] = 8'h00;
        mac_issue(32'h5555_5555, 32'h5555_5555);
        n = 1;
        while (!fault && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 15);
        check("timeout_vec_hold", xb_input_vector, 32'h5555_5555);
        check("timeout_r_valid", r_valid, 1);
        drain(1'b0);
        check("timeout_x_ready", x_ready, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        respond = 1'b1;

        // Hand-set sums 5, -4, 3 (requantized when the feature is built in).
        use_override = 1'b1;
        override_val = 128'h03FC05;
        exp_r[0] = expect_r(5);
        exp_r[1] = expect_r(-4);
        exp_r[2] = expect_r(3);
        for (int c = 3; c < 16; c++) exp_r[c] = expect_r(0);
        mac_issue(32'h5555_5555, 32'h5555_5555);
        tick();
        tick();
        check("override_r_valid", r_valid, 1);
        drain(1'b0);
        check("override_fault", fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rram_cim_sequencer.md
Name: rram_cim_sequencer

Overview:
Initiator-side controller for the ternary RRAM compute-in-memory crossbar.
- Accepts a row-major weight stream and programs it into the crossbar's write port.
- Accepts ternary activation vectors, issues MAC requests, and captures the per-column signed 8-bit sums.
- Drains the sums as a serial column stream.
- Sits between the host/DMA fabric and the crossbar macro.

Parameters:
ROWS, 16, crossbar rows (input vector length)
COLS, 16, crossbar columns (results per MAC)
TIMEOUT, 15, max cycles from xb_mac_start to xb_mac_done before error
THRESH, 4, requantization threshold (used only with optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin weight load (accepted only in IDLE)
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted
w_data  in  2  trit: 10=-1, 00=0, 01=+1, 11=invalid
x_valid  in  1  activation vector valid
x_ready  out  1  activation vector accepted
x_data  in  ROWS*2  packed trits, row r at [2r+:2]
r_valid  out  1  result beat valid
r_ready  in  1  result beat accepted
r_data  out  8  signed column sum (or trit, see option)
r_col  out  clog2(COLS)  column index of r_data
r_last  out  1  high on column COLS-1 beat
busy  out  1  FSM not in IDLE
fault  out  1  sticky: invalid trit seen or MAC timeout
fault_clr  in  1  clears fault (IDLE only)
xb_wr_row  out  clog2(ROWS)  crossbar write row
xb_wr_col  out  clog2(COLS)  crossbar write column
xb_wr_data  out  2  crossbar write trit
xb_wr_en  out  1  crossbar write strobe
xb_input_vector  out  ROWS*2  crossbar MAC input
xb_mac_start  out  1  crossbar MAC request pulse
xb_mac_result  in  COLS*8  crossbar column sums
xb_mac_done  in  1  crossbar MAC complete pulse

Behaviour:
Clock and reset:
- Single clock clk; rst_n asynchronous active-low.
- All outputs reset to 0: w_ready, x_ready, r_valid, r_data, r_col, r_last, busy, fault, and all xb_*.
- FSM resets to IDLE; row/column counters and the result buffer clear.

FSM states:
- IDLE:
  - load_start -> LOAD, clearing the row/column counters.
  - Otherwise, x_valid -> MAC_ISSUE.
  - load_start has priority over x_valid in the same cycle.
  - x_ready is high only in IDLE.
- LOAD:
  - w_ready=1. On each w_valid&w_ready the next cycle drives xb_wr_en=1 with the current row/col and w_data.
  - Column increments first and wraps at COLS-1; row then increments.
  - After beat ROWS*COLS-1 -> IDLE. xb_wr_en is a one-cycle strobe per beat.
  - w_data=11 is written as 00 and sets fault.
- MAC_ISSUE:
  - x_data is latched into xb_input_vector on the IDLE accept.
  - xb_mac_start=1 for exactly one cycle, then -> MAC_WAIT.
  - Any 11 trit in x_data is forced to 00 and sets fault.
- MAC_WAIT:
  - xb_input_vector is held stable and the timeout counter increments.
  - xb_mac_done -> capture xb_mac_result into the COLS-entry buffer, then -> DRAIN.
  - Counter reaching TIMEOUT -> set fault, fill the buffer with zeros, then -> DRAIN.
- DRAIN:
  - r_valid=1 and data/col hold stable until r_ready.
  - Column 0 is presented first.
  - On r_ready at column COLS-1 (r_last=1): next cycle r_valid=0 and -> IDLE.
  - Back-to-back beats run at one per cycle while r_ready=1.

Latency:
- x accept -> xb_mac_start: 1 cycle.
- xb_mac_done -> first r_valid: 1 cycle.

Other rules:
- xb_mac_done outside MAC_WAIT is ignored.
- fault_clr and a new fault event in the same cycle: fault stays 1.
- Reset mid-LOAD: the crossbar keeps partially written cells. The sequencer restarts in IDLE and a full reload is required.
- r_data is sign-preserved from the crossbar; no saturation is applied here.

Optional Feature:
RRAM_CIM_REQUANT_EN
- Defined: each column sum is requantized before buffering:
  - sum >= THRESH -> 8'h01
  - sum <= -THRESH -> 8'h02 (trit 10)
  - otherwise -> 8'h00
  - This lets the output feed the next layer's x_data directly.
- Undefined: raw signed 8-bit sums are emitted and THRESH is unused.

Decomposition:
- Shared package rram_cim_pkg:
  - trit encoding constants TRIT_NEG=2'b10, TRIT_ZERO=2'b00, TRIT_POS=2'b01, TRIT_BAD=2'b11
  - FSM state enum
  - trit sanitize function (11 -> 00 plus flag)
- One natural sub-module: rram_cim_result_buf.
  - COLS x 8 capture register with serial drain pointer and r_last generation.
  - Holds the requant logic under the macro.

Test Plan:
- Load: load_start, then 256 beats with w_ready held.
  - Required: 256 xb_wr_en strobes; beat 17 writes row 1, col 1; busy drops the cycle after the last beat.
- MAC with all weights +1 and x_data all 01, using a crossbar model with done 2 cycles after start.
  - Required: xb_mac_start is a single cycle; 16 beats r_data=16, r_col 0..15; r_last only on col 15.
- Backpressure: r_ready toggles 1,0,0,1 during DRAIN.
  - Required: r_data/r_col hold while stalled; no beat is lost or duplicated.
- Invalid trits: w_data=11 on beat 0 and x_data row 3 = 11.
  - Required: xb_wr_data=00 and the row-3 input is 00; fault=1 until fault_clr in IDLE.
- Timeout: crossbar never asserts done.
  - Required: fault sets 15 cycles after start; 16 zero results drain; FSM returns to IDLE.
- Requant (macro defined, THRESH=4): column sums 5, -4, 3.
  - Required: r_data 01, 02, 00 respectively.
